rx_block_decoder_fsm: RTL and testbench
=======================================

// Module: rx_block_decoder_fsm
// PURPOSE
//  Receive-side 64b/66b block-sequence checker, directly downstream of clock_comp_rx.
//  Classifies each 66b block (C/S/D/T/E) and runs the IEEE 802.3 cl.82-style RX state machine.
//  Passes legal blocks through and replaces illegal ones with PCS_ERROR.
//  Drives o_fsm_control back to clock_comp_rx so idle insertion happens only where a control block is legal.
// PARAMETERS
//  NB_DATA_CODED   66   coded block width: [65:64] sync header, [63:56] block type
//  NB_ERR_CNT      16   width of saturating error-block counter
// PORTS
//  i_clock        in   1    clock
//  i_reset        in   1    synchronous, active-high reset
//  i_rf_enable    in   1    global enable; when low, all state and outputs hold
//  i_valid        in   1    i_data carries a block this cycle
//  i_block_lock   in   1    block lock from the sync-header aligner
//  i_hi_ber       in   1    high-BER indication
//  i_data         in   66   block from clock_comp_rx
//  o_data         out  66   decoded/substituted block
//  o_valid        out  1    o_data valid
//  o_fsm_control  out  1    1 = next block may legally be a control block (to clock_comp_rx)
//  o_state        out  3    current FSM state (debug/status)
//  o_err_cnt      out  16   count of PCS_ERROR blocks emitted, saturating
// BEHAVIOUR
//  Clock enable: everything below advances only when i_rf_enable && i_valid. Otherwise all regs hold and o_valid=0.
//  Reset values: state=RX_INIT, o_data=PCS_LFAULT, o_valid=0, o_err_cnt=0, o_fsm_control=0.
//  Reset mid-operation takes effect on the next edge. No partial block survives it.
//  Classification (combinational on i_data):
//   - hdr 2'b01 -> D
//   - hdr 2'b10 with type 8'hE0 -> C
//   - hdr 2'b10 with type 8'h78 -> S
//   - hdr 2'b10 with type in {87,99,AA,B4,CC,D2,E1,FF} -> T
//   - any other type, or hdr 2'b00/2'b11 -> E
//  Transitions (evaluated per accepted block):
//   - RX_INIT: C->RX_C; S->RX_D; else->RX_E
//   - RX_C:    C->RX_C; S->RX_D; else->RX_E
//   - RX_D:    D->RX_D; T->RX_T; else->RX_E
//   - RX_T:    C->RX_C; S->RX_D; else->RX_E
//   - RX_E:    C->RX_C; D->RX_D; T->RX_T; S or E->RX_E
//   - i_block_lock==0 or i_hi_ber==1 overrides everything: next state RX_INIT, o_data=PCS_LFAULT.
//     This override is applied even when i_valid=0.
//  Output: 1-cycle latency, registered. o_data=i_data if next state != RX_E, else PCS_ERROR.
//  o_valid is the registered (i_rf_enable && i_valid).
//  o_fsm_control = (state==RX_C)||(state==RX_T). Decoded from registered state only; no comb path from i_data.
//  o_err_cnt increments on each PCS_ERROR emitted and sticks at 2^NB_ERR_CNT-1.
//  The counter does not reset on lock loss, only on i_reset.
//  o_state encoding: INIT=0, C=1, D=2, T=3, E=4. Codes 5..7 are illegal; an illegal state recovers to RX_INIT on the next edge.
// STRUCTURE
//  Shared package/include pcs_rx_pkg, holding:
//   - HDR_DATA, HDR_CTRL
//   - BT_IDLE(8'hE0), BT_START(8'h78), BT_TERM0..7
//   - block class codes
//   - state codes
//   - PCS_IDLE (66'h2_E0_00000000000000)
//   - PCS_ERROR (type 8'hE0, eight 7-bit /E/=7'h1E)
//   - PCS_LFAULT
//  PCS_IDLE is shared with clock_comp_rx.
//  One sub-module: rx_block_classifier (pure combinational, i_data -> 3b class).
//  The FSM, output register and counter live in the top module.
// TESTING
//  1. Reset, lock=1, send 4xPCS_IDLE -> o_state 0->1, o_data=PCS_IDLE, o_fsm_control=1 from 2nd block, err_cnt=0.
//  2. C,S(78),D,D,T(FF),C -> states C,D,D,D,T,C; all blocks pass unchanged; o_fsm_control=0 while in RX_D.
//  3. In RX_D inject C block -> o_data=PCS_ERROR, state=4, err_cnt=1; following D -> state=2, data passes.
//  4. Header 2'b11 block in RX_C -> PCS_ERROR; 0xFFFF errors then one more -> err_cnt stays 0xFFFF.
//  5. Drop i_block_lock mid-packet -> next edge state=0, o_data=PCS_LFAULT; restore + C -> RX_C.
//  6. i_valid/i_rf_enable toggled low mid-stream -> state/o_data hold, o_valid=0; sequence results identical to test 2.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared 64b/66b receive-side constants: sync headers, block types, state codes
// and the canned blocks substituted by the decoder (PCS_IDLE also used by clock_comp_rx).
package pcs_rx_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE  = 8'hE0;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_TERM0 = 8'h87;
  localparam logic [7:0] BT_TERM1 = 8'h99;
  localparam logic [7:0] BT_TERM2 = 8'hAA;
  localparam logic [7:0] BT_TERM3 = 8'hB4;
  localparam logic [7:0] BT_TERM4 = 8'hCC;
  localparam logic [7:0] BT_TERM5 = 8'hD2;
  localparam logic [7:0] BT_TERM6 = 8'hE1;
  localparam logic [7:0] BT_TERM7 = 8'hFF;

  typedef enum logic [2:0] {
    BLK_C = 3'd0,
    BLK_S = 3'd1,
    BLK_D = 3'd2,
    BLK_T = 3'd3,
    BLK_E = 3'd4
  } blk_class_t;

  localparam logic [2:0] RX_INIT = 3'd0;
  localparam logic [2:0] RX_C    = 3'd1;
  localparam logic [2:0] RX_D    = 3'd2;
  localparam logic [2:0] RX_T    = 3'd3;
  localparam logic [2:0] RX_E    = 3'd4;

  localparam logic [65:0] PCS_IDLE   = 66'h2_E0_00000000000000;
  localparam logic [65:0] PCS_ERROR  = {HDR_CTRL, BT_IDLE, {8{7'h1E}}};
  // Local-fault ordered set: type 0x4B, seq data 00_00_01, O-code 0, idles in lanes 4..7.
  localparam logic [65:0] PCS_LFAULT = {HDR_CTRL, 8'h4B, 24'h00_0001, 4'h0, 28'h0};

endpackage

// File: rtl/rx_block_decoder_fsm_if.sv
// Block bus between clock_comp_rx and the receive block decoder, plus decoder status.
// Handshake: i_valid qualifies i_data in the cycle it is high; there is no ready, the
// decoder accepts every qualified block. o_valid qualifies o_data the same way.
interface rx_block_decoder_fsm_if #(
  parameter int NB_DATA_CODED = 66,
  parameter int NB_ERR_CNT    = 16
);
  logic                     i_valid;
  logic                     i_block_lock;
  logic                     i_hi_ber;
  logic [NB_DATA_CODED-1:0] i_data;
  logic [NB_DATA_CODED-1:0] o_data;
  logic                     o_valid;
  logic                     o_fsm_control;
  logic [2:0]               o_state;
  logic [NB_ERR_CNT-1:0]    o_err_cnt;

  modport master (
    output i_valid, i_block_lock, i_hi_ber, i_data,
    input  o_data, o_valid, o_fsm_control, o_state, o_err_cnt
  );

  modport slave (
    input  i_valid, i_block_lock, i_hi_ber, i_data,
    output o_data, o_valid, o_fsm_control, o_state, o_err_cnt
  );
endinterface

// File: rtl/rx_block_classifier.sv
// Combinational 66b block classifier: sync header + block type -> C/S/D/T/E class.
module rx_block_classifier
  import pcs_rx_pkg::*;
#(
  parameter int NB_DATA_CODED = 66
) (
  input  logic [NB_DATA_CODED-1:0] i_data,
  output blk_class_t               o_class
);
  logic [1:0] hdr;
  logic [7:0] btype;
  logic       unused_payload;

  assign hdr            = i_data[NB_DATA_CODED-1:NB_DATA_CODED-2];
  assign btype          = i_data[NB_DATA_CODED-3:NB_DATA_CODED-10];
  assign unused_payload = ^i_data[NB_DATA_CODED-11:0];

  always_comb begin
    o_class = BLK_E;
    if (hdr == HDR_DATA) begin
      o_class = BLK_D;
    end else if (hdr == HDR_CTRL) begin
      case (btype)
        BT_IDLE:  o_class = BLK_C;
        BT_START: o_class = BLK_S;
        BT_TERM0, BT_TERM1, BT_TERM2, BT_TERM3,
        BT_TERM4, BT_TERM5, BT_TERM6, BT_TERM7: o_class = BLK_T;
        default:  o_class = BLK_E;
      endcase
    end
  end
endmodule

// File: rtl/rx_block_decoder_fsm.sv
// 64b/66b receive block-sequence checker: tracks the RX state machine, passes legal
// blocks, substitutes PCS_ERROR for illegal ones and counts the substitutions.
module rx_block_decoder_fsm
  import pcs_rx_pkg::*;
#(
  parameter int NB_DATA_CODED = 66,
  parameter int NB_ERR_CNT    = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rf_enable,
  rx_block_decoder_fsm_if.slave bus
);
  blk_class_t               blk_class;
  logic [2:0]               state;
  logic [2:0]               next_state;
  logic [NB_DATA_CODED-1:0] data_q;
  logic                     valid_q;
  logic [NB_ERR_CNT-1:0]    err_cnt;
  logic                     lock_ok;
  logic                     state_illegal;

  rx_block_classifier #(.NB_DATA_CODED(NB_DATA_CODED)) u_classifier (
    .i_data  (bus.i_data),
    .o_class (blk_class)
  );

  assign lock_ok       = bus.i_block_lock && !bus.i_hi_ber;
  assign state_illegal = (state > RX_E);

  always_comb begin
    next_state = RX_INIT;
    case (state)
      RX_INIT, RX_C, RX_T: begin
        if (blk_class == BLK_C)      next_state = RX_C;
        else if (blk_class == BLK_S) next_state = RX_D;
        else                         next_state = RX_E;
      end
      RX_D: begin
        if (blk_class == BLK_D)      next_state = RX_D;
        else if (blk_class == BLK_T) next_state = RX_T;
        else                         next_state = RX_E;
      end
      RX_E: begin
        if (blk_class == BLK_C)      next_state = RX_C;
        else if (blk_class == BLK_D) next_state = RX_D;
        else if (blk_class == BLK_T) next_state = RX_T;
        else                         next_state = RX_E;
      end
      default: next_state = RX_INIT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= RX_INIT;
      data_q  <= PCS_LFAULT;
      valid_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      valid_q <= i_rf_enable && bus.i_valid;
      if (state_illegal) begin
        // Corrupted state register recovers regardless of enable.
        state <= RX_INIT;
      end else if (i_rf_enable) begin
        // Lock loss / high BER wins over any block, even an unqualified cycle.
        if (!lock_ok) begin
          state  <= RX_INIT;
          data_q <= PCS_LFAULT;
        end else if (bus.i_valid) begin
          state  <= next_state;
          data_q <= (next_state == RX_E) ? PCS_ERROR : bus.i_data;
          if ((next_state == RX_E) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_state       = state;
  assign bus.o_err_cnt     = err_cnt;
  assign bus.o_fsm_control = (state == RX_C) || (state == RX_T);

endmodule

// File: tb/tb_rx_block_decoder_fsm.sv
// Self-checking bench for rx_block_decoder_fsm: directed scenarios plus randomized
// traffic against a class-driven reference model of the block-sequence rules.
module tb_rx_block_decoder_fsm;
  import pcs_rx_pkg::*;

  // ---------------- clock / reset ----------------
  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  logic i_rf_enable = 1'b0;

  always #5 i_clock = ~i_clock;

  rx_block_decoder_fsm_if bus ();

  rx_block_decoder_fsm dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rf_enable (i_rf_enable),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [86:0] obs;
  assign obs = {bus.o_state, bus.o_valid, bus.o_fsm_control, bus.o_err_cnt, bus.o_data};

  // ---------------- reference model ----------------
  int          m_state;
  logic [65:0] m_data;
  logic        m_valid;
  int          m_err;

  logic [7:0]  term_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  logic [65:0] pkt [6];
  logic [2:0]  pkt_states [6] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd1};
  logic [65:0] exp_q [$];

  function automatic byte classify(input logic [65:0] d);
    if (d[65:64] == 2'b01) return "D";
    if (d[65:64] != 2'b10) return "E";
    if (d[63:56] == 8'hE0) return "C";
    if (d[63:56] == 8'h78) return "S";
    foreach (term_types[i]) if (d[63:56] == term_types[i]) return "T";
    return "E";
  endfunction

  // Where each block class may legally land, given the state it arrives in.
  function automatic int successor(input int s, input byte c);
    case (c)
      "C":     return (s == 2) ? 4 : 1;
      "S":     return (s == 0 || s == 1 || s == 3) ? 2 : 4;
      "D":     return (s == 2 || s == 4) ? 2 : 4;
      "T":     return (s == 2 || s == 4) ? 3 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic void model_step(input logic [65:0] d, input logic v, en, lock, hb);
    if (!en) begin
      m_valid = 1'b0;
      return;
    end
    m_valid = v;
    if (!lock || hb) begin
      m_state = 0;
      m_data  = PCS_LFAULT;
    end else if (v) begin
      m_state = successor(m_state, classify(d));
      if (m_state == 4) begin
        m_data = PCS_ERROR;
        if (m_err < 65535) m_err++;
      end else begin
        m_data = d;
      end
    end
  endfunction

  function automatic logic [86:0] exp_vec();
    return {m_state[2:0], m_valid, (m_state == 1 || m_state == 3), m_err[15:0], m_data};
  endfunction

  function automatic logic [55:0] r56();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[55:0];
  endfunction

  function automatic logic [65:0] mk_blk(input byte c);
    logic [65:0] b;
    case (c)
      "C": b = PCS_IDLE;
      "S": b = {HDR_CTRL, BT_START, r56()};
      "D": b = {HDR_DATA, $urandom(), $urandom()};
      "T": b = {HDR_CTRL, term_types[$urandom_range(0, 7)], r56()};
      default: begin
        case ($urandom_range(0, 2))
          0:       b = {2'b00, $urandom(), $urandom()};
          1:       b = {2'b11, $urandom(), $urandom()};
          default: b = {HDR_CTRL, 8'h1E, r56()};
        endcase
      end
    endcase
    return b;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge i_clock);
    i_reset          = 1'b1;
    i_rf_enable      = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_block_lock = 1'b1;
    bus.i_hi_ber     = 1'b0;
    bus.i_data       = '0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    m_state = 0;
    m_data  = PCS_LFAULT;
    m_valid = 1'b0;
    m_err   = 0;
  endtask

  task automatic drive(input logic [65:0] d, input logic v, en, lock, hb);
    @(negedge i_clock);
    bus.i_data       = d;
    bus.i_valid      = v;
    i_rf_enable      = en;
    bus.i_block_lock = lock;
    bus.i_hi_ber     = hb;
    model_step(d, v, en, lock, hb);
    @(posedge i_clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", obs, exp_vec());
    end
    checks++;
    if (bus.o_state !== 3'd0 || bus.o_data !== PCS_LFAULT || bus.o_valid !== 1'b0 ||
        bus.o_err_cnt !== 16'd0 || bus.o_fsm_control !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got state %0d data %h valid %b cnt %0d ctl %b want 0 %h 0 0 0",
               bus.o_state, bus.o_data, bus.o_valid, bus.o_err_cnt, bus.o_fsm_control, PCS_LFAULT);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 4; k++) begin
      drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL idle_model[%0d]: got %h want %h", k, obs, exp_vec());
      end
      checks++;
      if (bus.o_state !== 3'd1 || bus.o_data !== PCS_IDLE || bus.o_fsm_control !== 1'b1 ||
          bus.o_err_cnt !== 16'd0) begin
        errors++;
        $display("FAIL idle_direct[%0d]: got state %0d data %h ctl %b cnt %0d want 1 %h 1 0",
                 k, bus.o_state, bus.o_data, bus.o_fsm_control, bus.o_err_cnt, PCS_IDLE);
      end
    end
  endtask

  task automatic test_packet();
    byte cls [6] = '{"C", "S", "D", "D", "T", "C"};
    for (int k = 0; k < 6; k++) begin
      pkt[k] = (k == 4) ? {HDR_CTRL, BT_TERM7, r56()} : mk_blk(cls[k]);
      drive(pkt[k], 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL packet_model[%0d]: got %h want %h", k, obs, exp_vec());
      end
      checks++;
      if (bus.o_state !== pkt_states[k] || bus.o_data !== pkt[k]) begin
        errors++;
        $display("FAIL packet_direct[%0d]: got state %0d data %h want %0d %h",
                 k, bus.o_state, bus.o_data, pkt_states[k], pkt[k]);
      end
    end
  endtask

  task automatic test_error_block();
    logic [65:0] d;
    do_reset();
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("S"), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("D"), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_state !== 3'd4 || bus.o_data !== PCS_ERROR ||
        bus.o_err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL c_in_data: got %h want %h", obs, exp_vec());
    end
    d = mk_blk("D");
    drive(d, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_state !== 3'd2 || bus.o_data !== d) begin
      errors++;
      $display("FAIL data_after_err: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    drive({2'b11, $urandom(), $urandom()}, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_data !== PCS_ERROR || bus.o_err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL hdr11_in_c: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 65534; i++) begin
      drive(mk_blk("E"), 1'b1, 1'b1, 1'b1, 1'b0);
      if (i % 8192 == 0) begin
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL err_run[%0d]: got %h want %h", i, obs, exp_vec());
        end
      end
    end
    checks++;
    if (bus.o_err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_cnt_full: got %h want ffff", bus.o_err_cnt);
    end
    drive(mk_blk("E"), 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_cnt_sat: got cnt %h want ffff", bus.o_err_cnt);
    end
  endtask

  task automatic test_lock_loss();
    do_reset();
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("S"), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("D"), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("D"), 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_state !== 3'd0 || bus.o_data !== PCS_LFAULT) begin
      errors++;
      $display("FAIL lock_drop: got %h want %h", obs, exp_vec());
    end
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || bus.o_state !== 3'd1) begin
      errors++;
      $display("FAIL lock_restore: got %h want %h", obs, exp_vec());
    end
    drive(mk_blk("S"), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(mk_blk("D"), 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs !== exp_vec() || bus.o_state !== 3'd0 || bus.o_data !== PCS_LFAULT ||
        bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL hi_ber_no_valid: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_gaps();
    logic [65:0] want;
    do_reset();
    drive(PCS_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) exp_q.push_back(pkt[k]);
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        case ($urandom_range(0, 2))
          0:       drive(mk_blk("E"), 1'b0, 1'b1, 1'b1, 1'b0);
          1:       drive(mk_blk("E"), 1'b1, 1'b0, 1'b1, 1'b0);
          default: drive(mk_blk("E"), 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
        checks++;
        if (obs !== exp_vec() || bus.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold[%0d]: got %h want %h", k, obs, exp_vec());
        end
      end
      drive(pkt[k], 1'b1, 1'b1, 1'b1, 1'b0);
      want = exp_q.pop_front();
      checks++;
      if (obs !== exp_vec() || bus.o_state !== pkt_states[k] || bus.o_data !== want) begin
        errors++;
        $display("FAIL gap_packet[%0d]: got state %0d data %h want %0d %h",
                 k, bus.o_state, bus.o_data, pkt_states[k], want);
      end
    end
  endtask

  task automatic test_random();
    byte cls [5] = '{"C", "S", "D", "T", "E"};
    byte c;
    logic v, en, lock, hb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c    = cls[$urandom_range(0, 4)];
      v    = ($urandom_range(0, 9) != 0);
      en   = ($urandom_range(0, 9) != 0);
      lock = ($urandom_range(0, 29) != 0);
      hb   = ($urandom_range(0, 39) == 0);
      drive(mk_blk(c), v, en, lock, hb);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.i_valid      = 1'b0;
    bus.i_block_lock = 1'b1;
    bus.i_hi_ber     = 1'b0;
    bus.i_data       = '0;
    test_reset();
    test_idle();
    test_packet();
    test_error_block();
    test_lock_loss();
    test_gaps();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
